// File: rtl/data_mem_lsu.sv
// Byte-addressable RISC-V load/store data memory with configurable access latency.
// Valid/ready request side, valid-only response pulse, lane-select, extension and error checks.
module data_mem_lsu #(
   parameter int unsigned W       = 32,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned BASE    = 0,
   parameter int unsigned LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [1:0]   req_size,
   input  logic         req_unsigned,
   input  logic [W-1:0] req_addr,
   input  logic [W-1:0] req_wdata,
   output logic         resp_valid,
   output logic [W-1:0] resp_rdata,
   output logic         resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          ready_q;
   logic [W-1:0]  rdata_d;
   logic          err_d;

   // Contents survive reset; zero at power-up.
   logic [3:0][7:0] mem [DEPTH] = '{default: '0};

   logic [W-1:0]   off;
   logic [1:0]     lane;
   logic [W-3:0]   widx;
   logic [AW-1:0]  idx;
   logic           err_c;
   logic           accept_c;
   logic [3:0][7:0] rword;
   logic [W-1:0]   load_c;
   logic [3:0]     be_c;
   logic [W-1:0]   wrep_c;
   logic [7:0]     lb;
   logic [15:0]    lh;

   assign off      = req_addr - W'(BASE);
   assign lane     = off[1:0];
   assign widx     = off[W-1:2];
   assign idx      = widx[AW-1:0];
   assign rword    = mem[idx];
   assign accept_c = req_valid && req_ready;

   // Negative offsets wrap to huge word indices, so one compare covers both range faults.
   assign err_c = (req_size == 2'b11)
               || ((req_size == 2'b01) && lane[0])
               || ((req_size == 2'b10) && (lane != 2'b00))
               || (widx >= (W-2)'(DEPTH));

   // Lane extraction and sign/zero extension for loads.
   always_comb begin
      load_c = '0;
      lb     = rword[lane];
      lh     = lane[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
      case (req_size)
         2'b00:   load_c = req_unsigned ? {24'h0, lb} : {{24{lb[7]}}, lb};
         2'b01:   load_c = req_unsigned ? {16'h0, lh} : {{16{lh[15]}}, lh};
         2'b10:   load_c = rword;
         default: load_c = '0;
      endcase
   end

   // Byte enables and store data replicated so every enabled lane sees its byte.
   always_comb begin
      be_c   = 4'b0000;
      wrep_c = req_wdata;
      case (req_size)
         2'b00: begin
            be_c   = 4'b0001 << lane;
            wrep_c = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_c   = lane[1] ? 4'b1100 : 4'b0011;
            wrep_c = {2{req_wdata[15:0]}};
         end
         2'b10:   be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept_c && req_we && !err_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[idx][i] <= wrep_c[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      rdata_d = resp_rdata;
      err_d   = resp_err;
      case (state)
         IDLE: begin
            if (accept_c) begin
               rdata_d = (err_c || req_we) ? '0 : load_c;
               err_d   = err_c;
               cnt_d   = CW'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == CW'(1)) state_d = RESP;
            else               cnt_d   = cnt - CW'(1);
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ready_q    <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         ready_q    <= (state_d == IDLE);
         resp_valid <= (state_d == RESP);
         resp_rdata <= rdata_d;
         resp_err   <= err_d;
      end
   end

   // Gated by rst so no request is accepted in a reset cycle and ready rises right after release.
   assign req_ready = ready_q && !rst;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: two instances (LATENCY=1/BASE=0 and LATENCY=4/BASE=0x1000)
// checked every cycle against a byte-array reference model, plus directed literal cases.
module tb_data_mem_lsu;

   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic        req_we       [2];
   logic [1:0]  req_size     [2];
   logic        req_unsigned [2];
   logic [31:0] req_addr     [2];
   logic [31:0] req_wdata    [2];
   logic        resp_valid   [2];
   logic [31:0] resp_rdata   [2];
   logic        resp_err     [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   data_mem_lsu #(.W(32), .DEPTH(DEPTH), .BASE(0), .LATENCY(1)) u0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
      .resp_err(resp_err[0])
   );

   data_mem_lsu #(.W(32), .DEPTH(DEPTH), .BASE(32'h1000), .LATENCY(4)) u1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
      .resp_err(resp_err[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Reference model: flat byte array, expected response held until the next accept.
   for (genvar g = 0; g < 2; g++) begin : mdl
      localparam int unsigned LAT   = (g == 0) ? 1 : 4;
      localparam logic [31:0] BASEV = (g == 0) ? 32'h0 : 32'h1000;
      logic [7:0]  mm [DEPTH*4];
      bit          pend  = 1'b0;
      bit          armed = 1'b0;
      int          due   = 0;
      logic [31:0] h_rdata = '0;
      logic        h_err   = 1'b0;

      initial for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;

      always @(negedge clk) begin
         logic        busy;
         logic [31:0] off;
         logic [31:0] v;
         logic        e;
         int          n;
         busy = pend && (cyc <= due);
         if (armed) begin
            check($sformatf("u%0d req_ready cyc%0d", g, cyc), 32'(req_ready[g]), 32'(!rst && !busy));
            check($sformatf("u%0d resp_valid cyc%0d", g, cyc), 32'(resp_valid[g]), 32'(pend && (cyc == due)));
            check($sformatf("u%0d resp_rdata cyc%0d", g, cyc), resp_rdata[g], h_rdata);
            check($sformatf("u%0d resp_err cyc%0d", g, cyc), 32'(resp_err[g]), 32'(h_err));
         end
         if (rst) begin
            pend    = 1'b0;
            h_rdata = '0;
            h_err   = 1'b0;
            armed   = 1'b1;
         end else if (armed && req_valid[g] && !busy) begin
            off = req_addr[g] - BASEV;
            n   = 1 << req_size[g];
            e   = (req_size[g] == 2'b11) || ((off % 32'(n)) != 0) || ((off / 4) >= DEPTH);
            v   = '0;
            if (!e) begin
               for (int i = 0; i < n; i++) begin
                  if (req_we[g]) mm[off + 32'(i)] = req_wdata[g][8*i +: 8];
                  else           v = v | (32'(mm[off + 32'(i)]) << (8*i));
               end
               if (!req_we[g] && (n < 4) && !req_unsigned[g] && v[8*n-1])
                  v = v | ~((32'd1 << (8*n)) - 32'd1);
               if (req_we[g]) v = '0;
            end
            h_rdata = v;
            h_err   = e;
            pend    = 1'b1;
            due     = cyc + int'(LAT);
         end
      end
   end

   task automatic drive(input int k, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid[k]    = 1'b1;
      req_we[k]       = we;
      req_size[k]     = size;
      req_unsigned[k] = uns;
      req_addr[k]     = addr;
      req_wdata[k]    = wdata;
   endtask

   task automatic wait_accept(input int k, output int acc);
      acc = -1;
      for (int i = 0; i < 50 && acc < 0; i++) begin
         @(negedge clk);
         if (req_ready[k]) acc = cyc;
      end
      check($sformatf("u%0d accept seen", k), 32'(acc >= 0), 32'd1);
   endtask

   // One full transaction; returns the response payload and checks its latency.
   task automatic do_req(input int k, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
      int acc;
      int rc;
      @(posedge clk); #1;
      drive(k, we, size, uns, addr, wdata);
      wait_accept(k, acc);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      req_addr[k]  = $urandom;
      req_wdata[k] = $urandom;
      rc = -1;
      rd = '0;
      er = 1'b0;
      if (resp_valid[k]) begin
         rc = cyc;
         rd = resp_rdata[k];
         er = resp_err[k];
      end
      for (int i = 0; i < 40 && rc < 0; i++) begin
         @(negedge clk);
         if (resp_valid[k]) begin
            rc = cyc;
            rd = resp_rdata[k];
            er = resp_err[k];
         end
      end
      check($sformatf("u%0d latency @%08h", k, addr), 32'(rc - acc), (k == 0) ? 32'd1 : 32'd4);
   endtask

   task automatic expect_req(input string name, input int k, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd;
      logic        er;
      do_req(k, we, size, uns, addr, wdata, rd, er);
      check({name, " rdata"}, rd, exp_rd);
      check({name, " err"}, 32'(er), 32'(exp_er));
   endtask

   function automatic logic [31:0] rnd_addr(input logic [31:0] base);
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r < 11)      return base + 32'($urandom_range(0, 63));
      else if (r < 13) return base + 32'($urandom_range(DEPTH*4 - 16, DEPTH*4 + 16));
      else if (r < 14) return base - 32'($urandom_range(1, 8));
      else             return 32'($urandom);
   endfunction

   initial begin
      #500000;
      $display("FAIL global timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int a1, a2, a3, seen;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'b00;
         req_unsigned[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      end
      // Request held during reset must not be taken.
      req_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("u0 ready after release", 32'(req_ready[0]), 32'd1);
      check("u1 ready after release", 32'(req_ready[1]), 32'd1);

      // LATENCY=1, BASE=0 directed cases
      expect_req("sw 0x10",  0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h800000FF, 32'h0, 1'b0);
      expect_req("lw 0x10",  0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h800000FF, 1'b0);
      expect_req("lb 0x10",  0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0);
      expect_req("lbu 0x13", 0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
      expect_req("lh 0x12",  0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8000, 1'b0);
      expect_req("lhu 0x12", 0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008000, 1'b0);
      expect_req("sb 0x11",  0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AB, 32'h0, 1'b0);
      expect_req("sh 0x12",  0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, 32'h0, 1'b0);
      expect_req("lw merged", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFEABFF, 1'b0);
      expect_req("lw 0x14 untouched", 0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
      expect_req("lw mis 0x12", 0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
      expect_req("sh mis 0x11", 0, 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
      expect_req("size3 st",    0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
      expect_req("size3 ld",    0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
      expect_req("sw 0x400",    0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
      expect_req("lw 0x400",    0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
      expect_req("lw after errs", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFEABFF, 1'b0);
      expect_req("lw last word", 0, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0);

      // LATENCY=4, BASE=0x1000: req_valid held high across three requests
      @(posedge clk); #1;
      drive(1, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h11223344);
      wait_accept(1, a1);
      @(posedge clk); #1;
      drive(1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
      wait_accept(1, a2);
      @(posedge clk); #1;
      drive(1, 1'b0, 2'b10, 1'b0, 32'h0FFC, 32'h0);
      wait_accept(1, a3);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      check("u1 b2b spacing 1", 32'(a2 - a1), 32'd5);
      check("u1 b2b spacing 2", 32'(a3 - a2), 32'd5);
      repeat (6) @(posedge clk);
      expect_req("u1 lw 0x1000", 1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h11223344, 1'b0);
      expect_req("u1 lw 0x0ffc", 1, 1'b0, 2'b10, 1'b0, 32'h0FFC, 32'h0, 32'h0, 1'b1);
      expect_req("u1 lw 0x1400", 1, 1'b0, 2'b10, 1'b0, 32'h1400, 32'h0, 32'h0, 1'b1);

      // Reset while in WAIT drops the load; the earlier store persists.
      expect_req("u1 sw 0x1010", 1, 1'b1, 2'b10, 1'b0, 32'h1010, 32'hA5A55A5A, 32'h0, 1'b0);
      @(posedge clk); #1;
      drive(1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0);
      wait_accept(1, a1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("u1 ready after mid reset", 32'(req_ready[1]), 32'd1);
      check("u1 rdata after mid reset", resp_rdata[1], 32'h0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid[1]) seen++;
      end
      check("u1 dropped resp count", 32'(seen), 32'd0);
      expect_req("u1 lw after reset", 1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 32'hA5A55A5A, 1'b0);

      // Randomized traffic on both instances, checked by the model every cycle.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            req_valid[k]    = ($urandom_range(0, 2) != 0);
            req_we[k]       = 1'($urandom_range(0, 1));
            req_size[k]     = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            req_unsigned[k] = 1'($urandom_range(0, 1));
            req_addr[k]     = rnd_addr((k == 0) ? 32'h0 : 32'h1000);
            req_wdata[k]    = $urandom;
         end
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      repeat (10) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
